baby_store_harness: RTL

//   Parametrised main store for the manchester_baby core, with a host load/dump port for cocotb benches.
//   CPU side: combinational read, clocked write.

---
 rtl/baby_pkg.sv | 20 ++
 rtl/baby_store_array.sv | 58 +++++
 rtl/baby_store_harness.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/baby_pkg.sv
`default_nettype none
// ============================================================================
// Package  : baby_pkg
// Purpose  : Shared types and default sizes for the Manchester Baby store.
// Revision : 1.0
// ============================================================================
package baby_pkg;

    localparam int BABY_WORD_W = 32;
    localparam int BABY_DEPTH  = 32;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOST = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/baby_store_array.sv
`default_nettype none
// ============================================================================
// Module   : baby_store_array
// Purpose  : DEPTH x WORD_W register store, two async read ports, one write port.
// Revision : 1.0
// ============================================================================
module baby_store_array
    import baby_pkg::*;
#(
    parameter int WORD_W         = BABY_WORD_W,
    parameter int DEPTH          = BABY_DEPTH,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [WORD_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [WORD_W-1:0] rdata_b_o
);

    localparam logic [ADDR_W:0] LINES = (ADDR_W + 1)'(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              wr_ok;

    // Addresses beyond the last line drop writes and read back as zero.
    assign wr_ok     = we_i && ({1'b0, waddr_i} < LINES);
    assign rdata_a_o = ({1'b0, raddr_a_i} < LINES) ? mem_q[raddr_a_i] : '0;
    assign rdata_b_o = ({1'b0, raddr_b_i} < LINES) ? mem_q[raddr_b_i] : '0;

    generate
        if (CLEAR_ON_RESET != 0) begin : g_clear
            always_ff @(posedge clock or posedge reset_i) begin
                if (reset_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                end else if (wr_ok) begin
                    mem_q[waddr_i] <= wdata_i;
                end
            end
        end else begin : g_keep
            // Contents survive reset; only writes issued during reset are blocked.
            always_ff @(posedge clock) begin
                if (wr_ok && !reset_i) begin
                    mem_q[waddr_i] <= wdata_i;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/baby_store_harness.sv
`default_nettype none
// ============================================================================
// Module   : baby_store_harness
// Purpose  : Baby main store with host load/peek port and auto-dump on stop lamp.
// Revision : 1.0
// ============================================================================
module baby_store_harness
    import baby_pkg::*;
#(
    parameter int WORD_W         = BABY_WORD_W,
    parameter int DEPTH          = BABY_DEPTH,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_data_i,
    input  logic              cpu_rw_en_i,
    output logic [WORD_W-1:0] cpu_data_o,
    output logic              cpu_hold_o,
    input  logic              stop_lamp_i,
    input  logic              host_valid_i,
    output logic              host_ready_o,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [WORD_W-1:0] host_data_i,
    output logic              host_rvalid_o,
    output logic [WORD_W-1:0] host_rdata_o,
    input  logic              host_mode_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [WORD_W-1:0] dump_data_o,
    output logic              dump_last_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              lamp_q;
    logic              hold_q, ready_q, rvalid_q, valid_q, last_q;
    logic              rvalid_d;

    logic              host_acc, dump_hs, lamp_rise, cpu_we;
    logic              we;
    logic [ADDR_W-1:0] waddr, rd_b_addr;
    logic [WORD_W-1:0] wdata, rd_b_data;

    assign host_acc  = host_valid_i && ready_q;
    assign dump_hs   = valid_q && dump_ready_i;
    assign lamp_rise = stop_lamp_i && !lamp_q;
    assign cpu_we    = (state_q == ST_RUN) && cpu_rw_en_i;

    assign we        = cpu_we || (host_acc && host_we_i);
    assign waddr     = host_acc ? host_addr_i : cpu_addr_i;
    assign wdata     = host_acc ? host_data_i : cpu_data_i;
    // Second read port is shared: dump pointer while dumping, host address otherwise.
    assign rd_b_addr = (state_q == ST_DUMP) ? ptr_q : host_addr_i;

    baby_store_array #(
        .WORD_W         (WORD_W),
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_array (
        .clock     (clock),
        .reset_i   (reset_i),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (cpu_addr_i),
        .rdata_a_o (cpu_data_o),
        .raddr_b_i (rd_b_addr),
        .rdata_b_o (rd_b_data)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rdata_d  = rdata_q;
        rvalid_d = host_acc && !host_we_i;
        unique case (state_q)
            ST_RUN: begin
                // Host request takes priority; a coincident lamp edge is lost.
                if (host_mode_i) begin
                    state_d = ST_HOST;
                end else if (lamp_rise) begin
                    state_d = ST_DUMP;
                    ptr_d   = '0;
                end
            end
            ST_HOST: begin
                if (host_acc && !host_we_i) begin
                    rdata_d = rd_b_data;
                end
                if (!host_mode_i && !host_acc) begin
                    state_d = ST_RUN;
                end
            end
            ST_DUMP: begin
                if (dump_hs) begin
                    if (ptr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (host_mode_i) begin
                    state_d = ST_HOST;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_RUN;
            ptr_q    <= '0;
            rdata_q  <= '0;
            lamp_q   <= 1'b0;
            hold_q   <= 1'b0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rdata_q  <= rdata_d;
            lamp_q   <= stop_lamp_i;
            hold_q   <= (state_d != ST_RUN);
            ready_q  <= (state_d == ST_HOST);
            rvalid_q <= rvalid_d;
            valid_q  <= (state_d == ST_DUMP);
            last_q   <= (state_d == ST_DUMP) && (ptr_d == LAST_ADDR);
        end
    end

    assign cpu_hold_o    = hold_q;
    assign host_ready_o  = ready_q;
    assign host_rvalid_o = rvalid_q;
    assign host_rdata_o  = rdata_q;
    assign dump_valid_o  = valid_q;
    assign dump_addr_o   = ptr_q;
    assign dump_last_o   = last_q;
    assign dump_data_o   = valid_q ? rd_b_data : '0;

endmodule
`default_nettype wire
